// File: rtl/lab3_pkg.sv
// Shared definitions for the 1011 serial sequence detector.
package lab3_pkg;

    // Pattern to detect, oldest bit in the MSB.
    localparam logic [3:0] PATTERN = 4'b1011;

    // FSM states: each names the longest pattern prefix seen so far.
    typedef enum logic [2:0] {
        S0 = 3'd0,  // no prefix
        S1 = 3'd1,  // "1"
        S2 = 3'd2,  // "10"
        S3 = 3'd3,  // "101"
        S4 = 3'd4   // "1011" complete
    } state_t;

endpackage

// File: rtl/lab3_sat_counter.sv
// Saturating match counter with a sticky overflow flag, falling-edge clocked.
module lab3_sat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    // Next count: clear wins over increment; an increment at the ceiling sets overflow.
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clr) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (inc) begin
            if (count_q == CNT_MAX) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Counter and flag registers, updated on the falling edge.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/lab3_seq_detector.sv
// Moore FSM detecting serial 1011 (overlapping) with a saturating match counter.
module lab3_seq_detector
    import lab3_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             din,
    input  logic             en,
    input  logic             clr,
    output logic             detect,
    output logic [CNT_W-1:0] match_count,
    output logic             overflow
);

    state_t state_q, state_d;
    logic   hit;

    // Next-state logic: advance only on enabled samples, otherwise hold.
    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                S0:      state_d = (din == PATTERN[3]) ? S1 : S0;
                S1:      state_d = (din == PATTERN[2]) ? S2 : S1;
                S2:      state_d = (din == PATTERN[1]) ? S3 : S0;
                S3:      state_d = (din == PATTERN[0]) ? S4 : S2;
                S4:      state_d = din ? S1 : S2;  // "1" restarts, "10" overlaps
                default: state_d = S0;
            endcase
        end
    end

    // State register on the falling edge; reset discards any partial pattern.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // A detection is counted exactly on the S3 -> S4 step.
    assign hit    = (state_q == S3) && (state_d == S4);
    assign detect = (state_q == S4);

    lab3_sat_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clock    (clock),
        .reset_n  (reset_n),
        .inc      (hit),
        .clr      (clr),
        .count    (match_count),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_lab3_seq_detector.sv
// Scoreboard bench: driver pushes model results, monitor pops and compares.
module tb_lab3_seq_detector;

    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clock;
    logic          reset_n;
    logic          din;
    logic          en;
    logic          clr;
    logic          detect;
    logic [CW-1:0] match_count;
    logic          overflow;

    typedef struct {
        bit det;
        int cnt;
        bit ovf;
        int id;
    } exp_t;

    exp_t exp_q[$];
    bit   hist[$];      // enabled bits consumed since the last reset (last 4 kept)
    int   m_cnt;
    bit   m_ovf;
    int   vectors;
    int   miscompares;
    int   txn;

    lab3_seq_detector #(.CNT_W(CW)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .din         (din),
        .en          (en),
        .clr         (clr),
        .detect      (detect),
        .match_count (match_count),
        .overflow    (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: detection means the last four enabled bits read 1,0,1,1.
    function automatic bit ends_in_pattern();
        if (hist.size() < 4) return 1'b0;
        return hist[0] == 1'b1 && hist[1] == 1'b0 && hist[2] == 1'b1 && hist[3] == 1'b1;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    // Drive one sample, let the falling edge consume it, queue the expectation.
    task automatic apply(input bit d, input bit e, input bit c);
        exp_t x;
        bit   new_hit;
        @(posedge clock);
        #1;
        din = d;
        en  = e;
        clr = c;
        @(negedge clock);
        new_hit = 1'b0;
        if (e) begin
            hist.push_back(d);
            if (hist.size() > 4) void'(hist.pop_front());
            new_hit = ends_in_pattern();
        end
        if (c) begin
            m_cnt = 0;
            m_ovf = 1'b0;
        end else if (new_hit) begin
            if (m_cnt == CMAX) m_ovf = 1'b1;
            else m_cnt = m_cnt + 1;
        end
        x.det = ends_in_pattern();
        x.cnt = m_cnt;
        x.ovf = m_ovf;
        x.id  = txn;
        txn++;
        exp_q.push_back(x);
    endtask

    // Immediate-effect check: all outputs must be zero while reset_n is low.
    task automatic check_zero(input string name);
        vectors++;
        if (detect !== 1'b0 || match_count !== '0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: got det=%b cnt=%0d ovf=%b, required det=0 cnt=0 ovf=0",
                     name, detect, match_count, overflow);
        end else begin
            $display("reset %s: det=0 cnt=0 ovf=0 ok", name);
        end
    endtask

    // Reset asserted between edges, outputs checked before any clock edge.
    task automatic pulse_reset(input string name);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero(name);
        model_reset();
        #1;
        reset_n = 1'b1;
    endtask

    // Monitor: outputs settle at each falling edge; compare at the rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clock);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                vectors++;
                if (detect !== x.det || match_count !== x.cnt[CW-1:0] || overflow !== x.ovf) begin
                    miscompares++;
                    $display("FAIL txn%0d: got det=%b cnt=%0d ovf=%b, required det=%b cnt=%0d ovf=%b",
                             x.id, detect, match_count, overflow, x.det, x.cnt, x.ovf);
                end else begin
                    $display("txn%0d: det=%b cnt=%0d ovf=%b ok", x.id, detect, match_count, overflow);
                end
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        txn         = 0;
        din         = 1'b0;
        en          = 1'b0;
        clr         = 1'b0;
        reset_n     = 1'b0;
        model_reset();
        #1;
        check_zero("power_on");
        @(posedge clock);
        #3;
        reset_n = 1'b1;

        // Basic detect
        apply(1, 1, 0); apply(0, 1, 0); apply(1, 1, 0); apply(1, 1, 0);
        // Overlap continuation: 0,1,1 completes a second match
        apply(0, 1, 0); apply(1, 1, 0); apply(1, 1, 0);
        // Detect held while disabled
        apply(1, 0, 0); apply(0, 0, 0);
        apply(0, 1, 1);
        // Enable hold mid-pattern
        apply(1, 1, 0); apply(0, 1, 0); apply(1, 1, 0);
        apply(0, 0, 0); apply(0, 0, 0); apply(0, 0, 0);
        apply(1, 1, 0);
        // Saturation: more detections than the counter can hold, then clear
        for (int i = 0; i < 5; i++) begin
            apply(1, 1, 0); apply(0, 1, 0); apply(1, 1, 0); apply(1, 1, 0);
        end
        apply(0, 1, 1);
        // Clear colliding with a detection
        apply(1, 1, 0); apply(0, 1, 0); apply(1, 1, 0); apply(1, 1, 1);
        // Async reset mid-pattern, then a single 1 must not detect
        apply(1, 1, 0); apply(0, 1, 0); apply(1, 1, 0);
        pulse_reset("mid_pattern");
        apply(1, 1, 0); apply(1, 1, 0);

        // Randomized traffic with occasional clears and resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) pulse_reset("random");
            apply(1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 29) == 0);
        end

        // Drain: every queued expectation must be consumed within a few cycles
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clock);
        #1;
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lab3_seq_detector.md
LAB3_SEQ_DETECTOR -- requirements
Module: lab3_seq_detector

Interface
REQ-001 SHALL have parameter CNT_W, default 4, width of the match counter (legal range 2..8).
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its falling edge.
REQ-003 SHALL have port reset_n, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port din, input, 1, serial data bit from the upstream negative-edge D flip-flop Q output.
REQ-005 SHALL have port en, input, 1, sample enable; din is consumed only on falling edges where en=1.
REQ-006 SHALL have port clr, input, 1, synchronous clear of match_count and overflow.
REQ-007 SHALL have port detect, output, 1, high while the FSM is in state S4 (pattern 1011 just completed).
REQ-008 SHALL have port match_count, output, CNT_W, number of detections since reset/clear, saturating.
REQ-009 SHALL have port overflow, output, 1, sticky flag, set when a detection occurs with match_count already saturated.

Function
REQ-010 SHALL detect the serial pattern 1011 (oldest bit first), overlapping occurrences allowed.
REQ-011 SHALL implement a Moore FSM with five states: S0 (no prefix), S1 ("1"), S2 ("10"), S3 ("101"), S4 ("1011").
REQ-012 SHALL apply the following transitions on a falling edge with en=1 (din=0 / din=1): S0->S0/S1; S1->S2/S1; S2->S0/S3; S3->S2/S4; S4->S2/S1.
REQ-013 SHALL hold the current state on any falling edge with en=0, regardless of din.
REQ-014 SHALL drive detect = 1 exactly when state is S4; detect is registered state decode, no combinational path from din.
REQ-015 SHALL assert detect in the cycle after the falling edge that samples the fourth pattern bit (latency 1 edge); it stays high while en=0 holds S4.
REQ-016 SHALL increment match_count by 1 on each falling edge where the FSM transitions S3->S4.
REQ-017 SHALL saturate match_count at 2^CNT_W-1; a detection at saturation leaves the count unchanged and sets overflow.
REQ-018 SHALL keep overflow at 1 once set, until clr or reset.
REQ-019 SHALL, on a falling edge with clr=1, set match_count=0 and overflow=0; clr has priority over a simultaneous increment (result 0, overflow 0).
REQ-020 SHALL leave the FSM unaffected by clr; detection and state advance continue on the same edge.

Reset
REQ-021 SHALL, while reset_n=0, immediately force state=S0, detect=0, match_count=0, overflow=0, independent of clock.
REQ-022 SHALL discard any partial pattern when reset asserts mid-sequence; after release, detection restarts from S0.
REQ-023 SHALL resume normal operation on the first falling edge of clock after reset_n returns to 1.

Structure
REQ-024 SHALL take the state encodings S0..S4 (3-bit) and the pattern constant 4'b1011 from a shared package lab3_pkg.
REQ-025 SHALL isolate the saturating counter with sticky overflow in sub-module lab3_sat_counter (parameter CNT_W; ports clock, reset_n, inc, clr, count, overflow).
REQ-026 SHALL keep the FSM next-state logic and state register in lab3_seq_detector.

Verification
REQ-027 SHALL cover basic detect: en=1, din stream 1,0,1,1 on four falling edges -> detect=1 after the 4th edge, match_count=1.
REQ-028 SHALL cover overlap: din 1,0,1,1,0,1,1 -> detect pulses after edges 4 and 7, match_count=2.
REQ-029 SHALL cover enable hold: din 1,0,1 with en=1, then 3 edges en=0 with din=0, then din=1 with en=1 -> detect=1, match_count=1.
REQ-030 SHALL cover saturation: CNT_W=2, four detections -> match_count=3, overflow=1; clr on next edge -> 0, 0.
REQ-031 SHALL cover clr collision: clr=1 on the edge of a S3->S4 transition -> detect=1, match_count=0, overflow=0.
REQ-032 SHALL cover async reset mid-pattern: after 1,0,1 pull reset_n low between edges -> all outputs 0 immediately; after release din 1 -> state S1, no detect.
